grf: RTL and testbench

- General register file for the pipelined MIPS core. Sits in the decode stage directly upstream of the branch comparator.
- Supplies the two operand words RD1/RD2 that the comparator tests for equality. The same operands go on to the ID/EX stage.
- Provides 2 combinational read ports and 1 clocked write port driven from write-back.
- Write-to-read bypass lets a value written back in a cycle be compared in that same cycle without an extra stall.

---
 rtl/grf_if.sv | 15 +
 rtl/grf.sv | 36 +++
 tb/tb_grf.sv | 119 +++++++++++
 3 files changed

// File: rtl/grf_if.sv
// grf_if: decode-stage register file access bundle (two read ports, one write-back port)
interface grf_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic              we;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  modport master (output a1, a2, a3, we, wd, input rd1, rd2);
  modport slave  (input a1, a2, a3, we, wd, output rd1, rd2);
endinterface

// File: rtl/grf.sv
// grf: MIPS general register file, 2 combinational reads, 1 clocked write, optional write-to-read bypass
module grf #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  grf_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [1:DEPTH-1];
  logic              wr;
  logic              hit1;
  logic              hit2;
  assign wr = reset && bus.we && bus.a3 != '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[bus.a3] <= bus.wd;
    end
  end
  // forwarding lets the branch comparator see a write-back value in the same cycle
  assign hit1 = BYPASS && wr && bus.a3 == bus.a1;
  assign hit2 = BYPASS && wr && bus.a3 == bus.a2;
  always_comb begin
    bus.rd1 = !reset || bus.a1 == '0 ? '0 : hit1 ? bus.wd : mem[bus.a1];
    bus.rd2 = !reset || bus.a2 == '0 ? '0 : hit2 ? bus.wd : mem[bus.a2];
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (wr) $display("%0t grf: $%0d <= 0x%08h", $time, bus.a3, bus.wd);
  end
`endif
endmodule

// File: tb/tb_grf.sv
// tb_grf: directed scoreboard bench driving a bypassing and a non-bypassing grf in lockstep
module tb_grf;
  logic clk = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  logic [31:0] q[$];
  grf_if ifb ();
  grf_if ifn ();
  grf #(.BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  grf #(.BYPASS(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(ifn));
  always #5 clk = ~clk;
  function automatic logic [31:0] val(input int i);
    logic [31:0] k;
    k = 32'h0101_0101;
    return 32'(i) * k;
  endfunction
  task automatic set(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                     input logic we, input logic [31:0] wd);
    ifb.a1 = a1; ifb.a2 = a2; ifb.a3 = a3; ifb.we = we; ifb.wd = wd;
    ifn.a1 = a1; ifn.a2 = a2; ifn.a3 = a3; ifn.we = we; ifn.wd = wd;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (q.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
      return;
    end
    e = q.pop_front();
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask
  task automatic step(input string tag, input logic [31:0] b1, input logic [31:0] b2,
                      input logic [31:0] n1, input logic [31:0] n2);
    q.push_back(b1); q.push_back(b2); q.push_back(n1); q.push_back(n2);
    #2;
    chk({tag, ".byp.rd1"}, ifb.rd1);
    chk({tag, ".byp.rd2"}, ifb.rd2);
    chk({tag, ".nob.rd1"}, ifn.rd1);
    chk({tag, ".nob.rd2"}, ifn.rd2);
  endtask
  initial begin
    reset = 1'b0;
    set(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    step("reset", 0, 0, 0, 0);
    set(7, 7, 7, 1, 32'hA5A5_A5A5);
    step("coll_pre", 0, 0, 0, 0);
    @(negedge clk);
    step("coll_post", 0, 0, 0, 0);
    reset = 1'b1;
    set(7, 7, 0, 0, 0);
    step("coll_rel", 0, 0, 0, 0);
    @(negedge clk);
    set(5, 5, 5, 1, 32'h1234_5678);
    step("w5_same", 32'h1234_5678, 32'h1234_5678, 0, 0);
    @(negedge clk);
    set(5, 0, 0, 0, 0);
    step("w5_after", 32'h1234_5678, 0, 32'h1234_5678, 0);
    #1 reset = 1'b0;
    step("rst_pulse", 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      set(5'(i), 5'(32 - i), 0, 0, 0);
      step($sformatf("clr%0d", i), 0, 0, 0, 0);
    end
    @(negedge clk);
    set(8, 8, 8, 1, 32'hDEAD_BEEF);
    step("w8_same", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    set(8, 8, 0, 0, 0);
    step("r8", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    set(9, 8, 0, 0, 0);
    step("r9", 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    set(0, 0, 0, 1, 32'hFFFF_FFFF);
    step("r0_same", 0, 0, 0, 0);
    @(negedge clk);
    set(0, 0, 0, 0, 0);
    step("r0_after", 0, 0, 0, 0);
    set(0, 0, 3, 1, 32'h1);
    @(negedge clk);
    set(0, 0, 4, 1, 32'h2);
    @(negedge clk);
    set(3, 4, 3, 1, 32'h2);
    step("byp3", 32'h2, 32'h2, 32'h1, 32'h2);
    @(negedge clk);
    set(3, 4, 0, 0, 0);
    step("byp3_after", 32'h2, 32'h2, 32'h2, 32'h2);
    set(6, 6, 6, 1, 32'h77);
    step("byp_both", 32'h77, 32'h77, 0, 0);
    @(negedge clk);
    set(6, 6, 0, 0, 0);
    step("r6", 32'h77, 32'h77, 32'h77, 32'h77);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      set(0, 0, 5'(i), 1, val(i));
    end
    @(negedge clk);
    set(0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++) begin
      set(5'(i), 5'(32 - i), 0, 0, 0);
      step($sformatf("sweep%0d", i), val(i), val(32 - i), val(i), val(32 - i));
    end
    set(0, 16, 0, 0, 0);
    step("sweep_r0", 0, val(16), 0, val(16));
    if (q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
